// File: rtl/multdiv_iter.sv
// Iterative integer multiply/divide unit: shift-add multiply, restoring divide,
// one bit per cycle, with signed/unsigned operands and a start/busy/done handshake.
module multdiv_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             exception
);

  // state | meaning
  // IDLE  | waiting for start, result/exception held
  // RUN   | one multiply or divide iteration per cycle
  // FIX   | sign correction, result select, done pulse
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  localparam logic [1:0]       OP_MUL   = 2'b00;
  localparam logic [1:0]       OP_MULH  = 2'b01;
  localparam logic [1:0]       OP_DIV   = 2'b10;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t               state_q, state_d;
  logic [1:0]           op_q, op_d;
  logic                 sgn_q, sgn_d;
  logic                 neg_q, neg_d;
  logic                 divz_q, divz_d;
  logic                 sovf_q, sovf_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 exc_q, exc_d;

  logic                 sign_a, sign_b;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH:0]       mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     quo, rem, fix_res;
  logic                 fix_exc;

  always_comb begin
    sign_a = is_signed & operand_a[WIDTH-1];
    sign_b = is_signed & operand_b[WIDTH-1];
    mag_a  = sign_a ? -operand_a : operand_a;
    mag_b  = sign_b ? -operand_b : operand_b;

    // acc holds {partial product, multiplier} or {partial remainder, dividend/quotient}
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    div_shift = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff  = div_shift - {1'b0, b_q};

    prod = (sgn_q & neg_q) ? -acc_q : acc_q;
    quo  = divz_q ? '0 : ((sgn_q & neg_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
    // a zero divisor leaves the dividend magnitude in the remainder half
    rem  = (sgn_q & neg_q) ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    case (op_q)
      OP_MUL: begin
        fix_res = prod[WIDTH-1:0];
        fix_exc = sgn_q ? (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}})
                        : (|prod[2*WIDTH-1:WIDTH]);
      end
      OP_MULH: begin
        fix_res = prod[2*WIDTH-1:WIDTH];
        fix_exc = 1'b0;
      end
      OP_DIV: begin
        fix_res = quo;
        fix_exc = divz_q | sovf_q;
      end
      default: begin
        fix_res = rem;
        fix_exc = divz_q | sovf_q;
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sgn_d    = sgn_q;
    neg_d    = neg_q;
    divz_d   = divz_q;
    sovf_d   = sovf_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    b_d      = b_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    exc_d    = exc_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          sgn_d   = is_signed;
          neg_d   = op[1] & op[0] ? sign_a : sign_a ^ sign_b;
          divz_d  = (operand_b == '0);
          sovf_d  = is_signed & (operand_a == {1'b1, {(WIDTH-1){1'b0}}}) & (&operand_b);
          cnt_d   = '0;
          acc_d   = op[1] ? {{WIDTH{1'b0}}, mag_a} : {{WIDTH{1'b0}}, mag_b};
          b_d     = op[1] ? mag_b : mag_a;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (!op_q[1]) begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end else if (!div_diff[WIDTH]) begin
          acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        result_d = fix_res;
        exc_d    = fix_exc;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      sgn_q    <= 1'b0;
      neg_q    <= 1'b0;
      divz_q   <= 1'b0;
      sovf_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      b_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sgn_q    <= sgn_d;
      neg_q    <= neg_d;
      divz_q   <= divz_d;
      sovf_q   <= sovf_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      exc_q    <= exc_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign exception = exc_q;

endmodule

// File: tb/tb_multdiv_iter.sv
// Directed bench for multdiv_iter: 32-bit vectors with hand-computed results
// and an 8-bit back-to-back stream checked against a behavioural model.
module tb_multdiv_iter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n;

  logic        start32, sgn32, busy32, done32, exc32;
  logic [1:0]  op32;
  logic [31:0] a32, b32, res32;

  logic        start8, sgn8, busy8, done8, exc8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8, res8;

  int n_checks = 0;
  int n_fail   = 0;

  multdiv_iter #(.WIDTH(32)) u_dut32 (
    .clock(clock), .reset_n(reset_n), .start(start32), .op(op32), .is_signed(sgn32),
    .operand_a(a32), .operand_b(b32), .busy(busy32), .done(done32),
    .result(res32), .exception(exc32)
  );

  multdiv_iter #(.WIDTH(8)) u_dut8 (
    .clock(clock), .reset_n(reset_n), .start(start8), .op(op8), .is_signed(sgn8),
    .operand_a(a8), .operand_b(b8), .busy(busy8), .done(done8),
    .result(res8), .exception(exc8)
  );

  // Drives one 32-bit operation and reports what the DUT produced; no checking here.
  task automatic do_op32(input logic [1:0] op, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, output int lat, output logic [31:0] res,
                         output logic exc, output logic done_after);
    op32 = op; sgn32 = sgn; a32 = a; b32 = b; start32 = 1'b1;
    lat = 0; res = '0; exc = 1'b0; done_after = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clock); #1;
      if (k == 1) begin
        start32 = 1'b0; a32 = $urandom(); b32 = $urandom(); op32 = ~op; sgn32 = ~sgn;
      end
      if (done32) begin
        lat = k; res = res32; exc = exc32;
        break;
      end
    end
    if (lat != 0) begin
      @(posedge clock); #1;
      done_after = done32;
    end
  endtask

  function automatic void ref8(input logic [1:0] op, input logic sgn, input logic [7:0] a,
                               input logic [7:0] b, output logic [7:0] r, output logic e);
    longint A, B, P, Q, R;
    A = sgn ? {{56{a[7]}}, a} : {56'd0, a};
    B = sgn ? {{56{b[7]}}, b} : {56'd0, b};
    P = A * B;
    r = '0; e = 1'b0;
    case (op)
      2'd0: begin r = P[7:0]; e = sgn ? (P < -128 || P > 127) : (P > 255); end
      2'd1: begin r = P[15:8]; e = 1'b0; end
      default: begin
        if (B == 0) begin
          r = (op == 2'd3) ? a : 8'h00; e = 1'b1;
        end else if (sgn && a == 8'h80 && b == 8'hFF) begin
          r = (op == 2'd3) ? 8'h00 : 8'h80; e = 1'b1;
        end else begin
          Q = A / B; R = A % B;
          r = (op == 2'd3) ? R[7:0] : Q[7:0]; e = 1'b0;
        end
      end
    endcase
  endfunction

  task automatic test_reset();
    n_checks++; if (busy32 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", busy32); end
    n_checks++; if (done32 !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b, expected 0", done32); end
    n_checks++; if (res32 !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h, expected 0", res32); end
    n_checks++; if (exc32 !== 1'b0) begin n_fail++; $display("FAIL reset_exception: got %b, expected 0", exc32); end
    n_checks++; if (busy8 !== 1'b0) begin n_fail++; $display("FAIL reset_busy8: got %b, expected 0", busy8); end
    reset_n = 1'b1;
    @(posedge clock); #1;
    n_checks++; if (busy32 !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b, expected 0", busy32); end
  endtask

  task automatic test_mul();
    int lat; logic [31:0] r; logic e, d;
    do_op32(2'b00, 1'b1, 32'hFFFFFFF9, 32'd6, lat, r, e, d);
    n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL mul_latency: got %0d, expected 34", lat); end
    n_checks++; if (r !== 32'hFFFFFFD6) begin n_fail++; $display("FAIL mul_neg7x6: got %h, expected ffffffd6", r); end
    n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL mul_neg7x6_exc: got %b, expected 0", e); end
    n_checks++; if (d !== 1'b0) begin n_fail++; $display("FAIL done_pulse_width: done still %b, expected 0", d); end
    do_op32(2'b01, 1'b1, 32'hFFFFFFF9, 32'd6, lat, r, e, d);
    n_checks++; if (r !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mulh_neg7x6: got %h, expected ffffffff", r); end
    n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL mulh_neg7x6_exc: got %b, expected 0", e); end
    do_op32(2'b00, 1'b1, 32'h00010000, 32'h00010000, lat, r, e, d);
    n_checks++; if (r !== 32'h0) begin n_fail++; $display("FAIL mul_ovf: got %h, expected 0", r); end
    n_checks++; if (e !== 1'b1) begin n_fail++; $display("FAIL mul_ovf_exc: got %b, expected 1", e); end
    do_op32(2'b01, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, r, e, d);
    n_checks++; if (r !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL mulhu_max: got %h, expected fffffffe", r); end
    n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL mulhu_max_exc: got %b, expected 0", e); end
    do_op32(2'b00, 1'b0, 32'h00012345, 32'h00000100, lat, r, e, d);
    n_checks++; if (r !== 32'h01234500) begin n_fail++; $display("FAIL mulu_small: got %h, expected 01234500", r); end
    n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL mulu_small_exc: got %b, expected 0", e); end
  endtask

  task automatic test_div();
    int lat; logic [31:0] r; logic e, d;
    do_op32(2'b10, 1'b1, 32'hFFFFFFEF, 32'd5, lat, r, e, d);
    n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL div_latency: got %0d, expected 34", lat); end
    n_checks++; if (r !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL div_neg17by5: got %h, expected fffffffd", r); end
    n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL div_neg17by5_exc: got %b, expected 0", e); end
    do_op32(2'b11, 1'b1, 32'hFFFFFFEF, 32'd5, lat, r, e, d);
    n_checks++; if (r !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL rem_neg17by5: got %h, expected fffffffe", r); end
    do_op32(2'b10, 1'b0, 32'hFFFFFFFF, 32'd16, lat, r, e, d);
    n_checks++; if (r !== 32'h0FFFFFFF) begin n_fail++; $display("FAIL divu_max: got %h, expected 0fffffff", r); end
    n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL divu_max_exc: got %b, expected 0", e); end
    do_op32(2'b11, 1'b1, 32'd17, 32'hFFFFFFFB, lat, r, e, d);
    n_checks++; if (r !== 32'd2) begin n_fail++; $display("FAIL rem_17byneg5: got %h, expected 00000002", r); end
  endtask

  task automatic test_div_special();
    int lat; logic [31:0] r; logic e, d;
    do_op32(2'b10, 1'b0, 32'd123, 32'd0, lat, r, e, d);
    n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL divz_latency: got %0d, expected 34", lat); end
    n_checks++; if (r !== 32'h0) begin n_fail++; $display("FAIL divz_quot: got %h, expected 0", r); end
    n_checks++; if (e !== 1'b1) begin n_fail++; $display("FAIL divz_exc: got %b, expected 1", e); end
    do_op32(2'b11, 1'b0, 32'd123, 32'd0, lat, r, e, d);
    n_checks++; if (r !== 32'd123) begin n_fail++; $display("FAIL remz: got %h, expected 0000007b", r); end
    n_checks++; if (e !== 1'b1) begin n_fail++; $display("FAIL remz_exc: got %b, expected 1", e); end
    do_op32(2'b10, 1'b1, 32'h80000000, 32'hFFFFFFFF, lat, r, e, d);
    n_checks++; if (r !== 32'h80000000) begin n_fail++; $display("FAIL div_sovf: got %h, expected 80000000", r); end
    n_checks++; if (e !== 1'b1) begin n_fail++; $display("FAIL div_sovf_exc: got %b, expected 1", e); end
    do_op32(2'b11, 1'b1, 32'h80000000, 32'hFFFFFFFF, lat, r, e, d);
    n_checks++; if (r !== 32'h0) begin n_fail++; $display("FAIL rem_sovf: got %h, expected 0", r); end
    n_checks++; if (e !== 1'b1) begin n_fail++; $display("FAIL rem_sovf_exc: got %b, expected 1", e); end
    do_op32(2'b11, 1'b1, 32'hFFFFFFFB, 32'd0, lat, r, e, d);
    n_checks++; if (r !== 32'hFFFFFFFB) begin n_fail++; $display("FAIL remz_neg: got %h, expected fffffffb", r); end
  endtask

  task automatic test_reset_abort();
    int dones;
    op32 = 2'b00; sgn32 = 1'b0; a32 = 32'd3; b32 = 32'd5; start32 = 1'b1;
    @(posedge clock); #1;
    start32 = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    n_checks++; if (busy32 !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b, expected 0", busy32); end
    n_checks++; if (res32 !== 32'h0) begin n_fail++; $display("FAIL abort_result: got %h, expected 0", res32); end
    n_checks++; if (exc32 !== 1'b0) begin n_fail++; $display("FAIL abort_exc: got %b, expected 0", exc32); end
    #2;
    reset_n = 1'b1;
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clock); #1;
      if (done32) dones++;
    end
    n_checks++; if (dones !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d done pulses, expected 0", dones); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_r; logic exp_e; int k;
    op8 = 2'd2; sgn8 = 1'b1; a8 = 8'hE5; b8 = 8'h07; start8 = 1'b1;
    ref8(op8, sgn8, a8, b8, exp_r, exp_e);
    for (int i = 0; i < 24; i++) begin
      k = 0;
      for (int c = 1; c <= 20; c++) begin
        @(posedge clock); #1;
        if (c == 1) begin
          n_checks++; if (busy8 !== 1'b1) begin n_fail++; $display("FAIL b2b_busy[%0d]: got %b, expected 1", i, busy8); end
          a8 = 8'($urandom()); b8 = 8'($urandom());
          op8 = 2'($urandom_range(0, 3)); sgn8 = 1'($urandom_range(0, 1));
        end
        if (done8) begin k = c; break; end
      end
      n_checks++; if (k !== 10) begin n_fail++; $display("FAIL b2b_period[%0d]: got %0d, expected 10", i, k); end
      if (k == 0) break;
      n_checks++; if (res8 !== exp_r) begin n_fail++; $display("FAIL b2b_result[%0d]: got %h, expected %h", i, res8, exp_r); end
      n_checks++; if (exc8 !== exp_e) begin n_fail++; $display("FAIL b2b_exc[%0d]: got %b, expected %b", i, exc8, exp_e); end
      if (i == 23) begin
        start8 = 1'b0;
      end else begin
        op8 = 2'(i); sgn8 = 1'(i >> 2);
        a8 = 8'($urandom()); b8 = 8'($urandom());
        if (i % 7 == 3) b8 = 8'h00;
        if (i == 14 || i == 15) begin a8 = 8'h80; b8 = 8'hFF; end
        ref8(op8, sgn8, a8, b8, exp_r, exp_e);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    start32 = 1'b0; sgn32 = 1'b0; op32 = 2'b00; a32 = '0; b32 = '0;
    start8 = 1'b0; sgn8 = 1'b0; op8 = 2'b00; a8 = '0; b8 = '0;
    repeat (2) @(posedge clock);
    #1;
    test_reset();
    test_mul();
    test_div();
    test_div_special();
    test_reset_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multdiv_iter.md
Name: multdiv_iter

Overview:
- Parametrised iterative integer multiply/divide unit; successor to the fixed 32-bit mult/div block in the processor datapath.
- Generalised in operand width.
- Adds the following, all behind one start/busy/done handshake:
  - signed and unsigned modes
  - high-half multiply result
  - remainder result
  - signed-overflow detection for divide
- Sits beside the ALU in execute; the pipeline stalls on busy.

Parameters:
- WIDTH, 32, operand and result width in bits; legal range 4..64.
- CNT_W, $clog2(WIDTH+1), iteration counter width. Derived; do not override.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only when busy=0.
- op  input  2  operation select: 00 MUL (low half), 01 MULH (high half), 10 DIV (quotient), 11 REM (remainder).
- is_signed  input  1  1 = two's-complement operands, 0 = unsigned.
- operand_a  input  WIDTH  multiplicand / dividend.
- operand_b  input  WIDTH  multiplier / divisor.
- busy  output  1  operation in flight.
- done  output  1  one-cycle pulse when result and exception are valid.
- result  output  WIDTH  selected result; holds until the next accepted start.
- exception  output  1  MUL overflow, divide-by-zero, or signed DIV/REM overflow; held with result.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - State IDLE; busy=0, done=0, result=0, exception=0.
  - All internal registers cleared.
  - Reset asserted mid-operation aborts it; no done is produced.
- States: IDLE -> RUN -> FIX -> IDLE.
- IDLE, start=1 at edge E0 (capture):
  - Latch op and is_signed.
  - Latch the magnitudes of both operands:
    - Signed mode: two's-complement negate when the MSB is 1.
    - Unsigned mode: raw operands.
  - Latch result sign: sign_a ^ sign_b for MUL/MULH/DIV; sign_a for REM.
  - Latch divzero = (operand_b == 0) and sovf = is_signed & (a == MIN) & (b == all-ones).
  - Counter := 0; busy:=1; done:=0.
- RUN, one iteration per edge E1..E_WIDTH:
  - MUL/MULH: radix-2 shift-add on a 2*WIDTH accumulator.
  - DIV/REM: restoring division; a trial subtract of the divisor from the shifted partial remainder sets the quotient bit when the result is non-negative.
  - The counter increments each iteration; leave RUN when counter == WIDTH-1.
- FIX, edge E_WIDTH+1:
  - Apply sign correction: negate the product, quotient or remainder when the latched sign is 1 (signed mode only).
  - Select the result by op:
    - MUL: low WIDTH bits.
    - MULH: high WIDTH bits.
    - DIV: quotient.
    - REM: remainder.
  - Write result and exception; done:=1, busy:=0.
- Latency: done is high in the cycle after edge E0+WIDTH+1; it is exactly 1 cycle wide.
- Throughput: start may be asserted in the done cycle; it is accepted at the next edge (back-to-back).
- start while busy=1 is ignored. Operands are not re-sampled during RUN; inputs may change freely.
- Exception and special-result rules:
  - MUL exception: the full signed/unsigned 2*WIDTH product is not representable in WIDTH bits.
    - Signed: high half is not the sign extension of bit WIDTH-1.
    - Unsigned: high half is nonzero.
  - MULH never raises exception.
  - Divide-by-zero, DIV/REM: quotient = 0, remainder = operand_a, exception=1. Full latency still applies.
  - Signed MIN / -1: quotient = MIN, remainder = 0, exception=1.
  - Rounding: quotient truncates toward zero; the remainder takes the sign of the dividend.
- The result register is written only in FIX.

Test Plan:
- WIDTH=32: reset_n pulse low mid-RUN of a MUL -> busy=0 and result=0 immediately; no done within 40 cycles.
- MUL, is_signed=1, a=-7 (0xFFFFFFF9), b=6 -> done exactly 34 cycles after start; result=0xFFFFFFD6; exception=0. MULH, same operands -> result=0xFFFFFFFF.
- MUL, is_signed=1, a=0x00010000, b=0x00010000 -> result=0; exception=1. Unsigned MULH, a=b=0xFFFFFFFF -> result=0xFFFFFFFE; exception=0.
- DIV, is_signed=1, a=-17, b=5 -> result=0xFFFFFFFD (-3). REM, same operands -> result=0xFFFFFFFE (-2). Unsigned DIV, a=0xFFFFFFFF, b=16 -> result=0x0FFFFFFF.
- DIV, b=0, a=123 -> result=0; exception=1. REM, b=0, a=123 -> result=123; exception=1. Signed DIV 0x80000000 / 0xFFFFFFFF -> result=0x80000000; exception=1.
- WIDTH=8 build: start held high continuously, with a new random operand pair presented on each done cycle -> an accepted start every 10 cycles; done every 10 cycles; every result matches the reference model; starts asserted while busy are ignored.
